// File: rtl/simon_pkg.sv
// Shared definitions for the SIMON block cipher cores.
// Holds the default word size / key-word count / round count, the FSM
// state type, the 62-bit z constant sequence used by the key schedule
// (bit 61 is the first element of the sequence), and the round function f().
// f() is written over a 64-bit container with the live width passed in,
// so a single function serves every word size up to 64 bits.
package simon_pkg;

    localparam int N_DEF = 16;
    localparam int M_DEF = 4;
    localparam int T_DEF = 32;

    // z0 sequence, first element in the MSB.
    localparam logic [61:0] Z_SEQ =
        62'b11111010_00100101_01100001_11001101_11110100_01001010_11000011_100110;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Wrap index (i - s) into the range [0, n).
    function automatic logic [5:0] rot_idx(input int i, input int s, input int n);
        int r;
        r = ((i - s) % n + n) % n;
        return 6'(r);
    endfunction

    // Bit i of f(x) = (rotl1(x) & rotl8(x)) ^ rotl2(x), rotations modulo n.
    function automatic logic simon_f_bit(input logic [63:0] x, input int n, input int i);
        logic b;
        if (i < n) begin
            b = (x[rot_idx(i, 1, n)] & x[rot_idx(i, 8, n)]) ^ x[rot_idx(i, 2, n)];
        end else begin
            b = 1'b0;
        end
        return b;
    endfunction

    // Full f(x) for an n-bit word held in the low bits of a 64-bit container.
    function automatic logic [63:0] simon_f(input logic [63:0] x, input int n);
        logic [63:0] r;
        r = 64'd0;
        for (int i = 0; i < 64; i++) begin
            r[i] = simon_f_bit(x, n, i);
        end
        return r;
    endfunction

endpackage

// File: rtl/simon_round.sv
// One combinational SIMON Feistel round.
// Ports: x, y  - current state words (N bits each)
//        k     - round key (N bits)
//        x_next, y_next - state after the round:
//        x_next = y ^ f(x) ^ k, y_next = x
module simon_round
    import simon_pkg::*;
#(
    parameter int N = N_DEF
) (
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    input  logic [N-1:0] k,
    output logic [N-1:0] x_next,
    output logic [N-1:0] y_next
);

    logic [63:0]  x_ext_s;
    logic [N-1:0] f_s;

    assign x_ext_s = 64'(x);

    for (genvar i = 0; i < N; i++) begin : g_f
        assign f_s[i] = simon_f_bit(x_ext_s, N, i);
    end

    assign x_next = y ^ f_s ^ k;
    assign y_next = x;

endmodule

// File: rtl/simon_encrypt_core.sv
// Iterative SIMON encrypt/decrypt core, one round per clock.
// Ports: clk, nReset (async, active-low)
//        keys_valid/keys     - expanded round keys, keys[0] first encrypt key
//        in_valid/in_ready   - request handshake carrying pt and decrypt
//        out_valid/out_ready - result handshake carrying ct
//        busy                - high while rounds are being executed
// Decryption reuses the encrypt datapath: the input words are swapped,
// the round keys are applied in reverse order, and the result is swapped
// back. ct/out_valid/busy are registered and only non-zero in DONE/RUN.
module simon_encrypt_core
    import simon_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int M = M_DEF,
    parameter int T = T_DEF
) (
    input  logic           clk,
    input  logic           nReset,
    input  logic           keys_valid,
    input  logic [N-1:0]   keys [T-1:0],
    input  logic           in_valid,
    output logic           in_ready,
    input  logic           decrypt,
    input  logic [2*N-1:0] pt,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] ct,
    output logic           busy
);

    localparam int             RCW     = $clog2(T);
    localparam logic [RCW-1:0] RC_LAST = RCW'(T - 1);
    localparam logic [RCW-1:0] RC_ONE  = RCW'(1);

    // M is only carried for schedule compatibility; reject nonsense values.
    if (M < 2 || M > 4) begin : g_m_range
        $error("simon_encrypt_core: M must be 2..4");
    end

    state_e         state_r;
    state_e         state_next_s;
    logic [RCW-1:0] rc_r;
    logic [N-1:0]   x_r;
    logic [N-1:0]   y_r;
    logic           mode_r;

    logic           accept_s;
    logic           round_s;
    logic           last_round_s;
    logic [RCW-1:0] key_idx_s;
    logic [N-1:0]   k_s;
    logic [N-1:0]   x_rnd_s;
    logic [N-1:0]   y_rnd_s;

    logic [2*N-1:0] ct_r;
    logic [2*N-1:0] ct_next_s;
    logic           out_valid_r;
    logic           out_valid_next_s;
    logic           busy_r;
    logic           busy_next_s;

    assign in_ready     = (state_r == ST_IDLE) && keys_valid;
    assign accept_s     = in_valid && in_ready;
    // A round only happens while keys stay valid; otherwise RUN aborts.
    assign round_s      = (state_r == ST_RUN) && keys_valid;
    assign last_round_s = round_s && (rc_r == RC_LAST);
    assign key_idx_s    = mode_r ? (RC_LAST - rc_r) : rc_r;
    assign k_s          = keys[key_idx_s];

    simon_round #(
        .N (N)
    ) u_round (
        .x      (x_r),
        .y      (y_r),
        .k      (k_s),
        .x_next (x_rnd_s),
        .y_next (y_rnd_s)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (!keys_valid) begin
                    state_next_s = ST_IDLE;
                end else if (last_round_s) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_DONE;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // FSM output logic: next values of the registered outputs.
    always_comb begin
        ct_next_s        = {(2*N){1'b0}};
        out_valid_next_s = 1'b0;
        busy_next_s      = (state_next_s == ST_RUN);
        if (state_next_s == ST_DONE) begin
            out_valid_next_s = 1'b1;
            if (state_r == ST_RUN) begin
                // Decrypt ran on swapped words, so swap the result back.
                ct_next_s = mode_r ? {y_rnd_s, x_rnd_s} : {x_rnd_s, y_rnd_s};
            end else begin
                ct_next_s = ct_r;
            end
        end else begin
            ct_next_s        = {(2*N){1'b0}};
            out_valid_next_s = 1'b0;
        end
    end

    // Registered outputs.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            ct_r        <= {(2*N){1'b0}};
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            ct_r        <= ct_next_s;
            out_valid_r <= out_valid_next_s;
            busy_r      <= busy_next_s;
        end
    end

    // Datapath: capture on accept, one round per edge while running.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            x_r    <= {N{1'b0}};
            y_r    <= {N{1'b0}};
            rc_r   <= {RCW{1'b0}};
            mode_r <= 1'b0;
        end else if (accept_s) begin
            if (decrypt) begin
                x_r <= pt[N-1:0];
                y_r <= pt[2*N-1:N];
            end else begin
                x_r <= pt[2*N-1:N];
                y_r <= pt[N-1:0];
            end
            mode_r <= decrypt;
            rc_r   <= {RCW{1'b0}};
        end else if (round_s) begin
            x_r  <= x_rnd_s;
            y_r  <= y_rnd_s;
            rc_r <= last_round_s ? {RCW{1'b0}} : (rc_r + RC_ONE);
        end else begin
            x_r    <= x_r;
            y_r    <= y_r;
            rc_r   <= rc_r;
            mode_r <= mode_r;
        end
    end

    assign ct        = ct_r;
    assign out_valid = out_valid_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_simon_encrypt_core.sv
// Self-checking bench for simon_encrypt_core (N=16, T=32).
// The reference computes the SIMON32/64 key schedule and cipher directly
// (decryption via the inverse Feistel round) and tracks the handshake
// timing with simple counters; a negedge process compares every cycle.
module tb_simon_encrypt_core;

    localparam int N = 16;
    localparam int M = 4;
    localparam int T = 32;

    logic          clk        = 1'b0;
    logic          nReset     = 1'b0;
    logic          keys_valid = 1'b0;
    logic [N-1:0]  keys [T-1:0];
    logic          in_valid   = 1'b0;
    logic          in_ready;
    logic          decrypt    = 1'b0;
    logic [31:0]   pt         = 32'd0;
    logic          out_valid;
    logic          out_ready  = 1'b0;
    logic [31:0]   ct;
    logic          busy;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    logic [15:0] rk [T];
    logic [61:0] z_seq = 62'b11111010_00100101_01100001_11001101_11110100_01001010_11000011_100110;

    simon_encrypt_core #(.N(N), .M(M), .T(T)) dut (
        .clk        (clk),
        .nReset     (nReset),
        .keys_valid (keys_valid),
        .keys       (keys),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .decrypt    (decrypt),
        .pt         (pt),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .ct         (ct),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [15:0] rotl(input logic [15:0] v, input int s);
        return (v << s) | (v >> (16 - s));
    endfunction

    function automatic logic [15:0] rotr(input logic [15:0] v, input int s);
        return (v >> s) | (v << (16 - s));
    endfunction

    function automatic logic [15:0] f_ref(input logic [15:0] v);
        return (rotl(v, 1) & rotl(v, 8)) ^ rotl(v, 2);
    endfunction

    function automatic logic [31:0] enc_ref(input logic [31:0] p);
        logic [15:0] x, y, t;
        x = p[31:16];
        y = p[15:0];
        for (int i = 0; i < T; i++) begin
            t = x;
            x = y ^ f_ref(x) ^ rk[i];
            y = t;
        end
        return {x, y};
    endfunction

    function automatic logic [31:0] dec_ref(input logic [31:0] c);
        logic [15:0] x, y, t;
        x = c[31:16];
        y = c[15:0];
        for (int i = T - 1; i >= 0; i--) begin
            t = y;
            y = x ^ f_ref(y) ^ rk[i];
            x = t;
        end
        return {x, y};
    endfunction

    // Reference behaviour: idle / running (rounds counted) / holding a result.
    logic        m_busy = 1'b0;
    logic        m_done = 1'b0;
    int          m_cnt  = 0;
    logic [31:0] m_res  = 32'd0;

    always @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_cnt  <= 0;
            m_res  <= 32'd0;
        end else if (m_busy) begin
            if (!keys_valid) begin
                m_busy <= 1'b0;
            end else begin
                m_cnt <= m_cnt + 1;
                if (m_cnt == T - 1) begin
                    m_busy <= 1'b0;
                    m_done <= 1'b1;
                end
            end
        end else if (m_done) begin
            if (out_ready) m_done <= 1'b0;
        end else if (in_valid && keys_valid) begin
            m_busy <= 1'b1;
            m_cnt  <= 0;
            m_res  <= decrypt ? dec_ref(pt) : enc_ref(pt);
        end
    end

    // Every-cycle comparison against the reference.
    always @(negedge clk) begin
        chk("out_valid", {31'd0, out_valid}, {31'd0, m_done});
        chk("ct", ct, m_done ? m_res : 32'd0);
        chk("busy", {31'd0, busy}, {31'd0, m_busy});
        chk("in_ready", {31'd0, in_ready}, {31'd0, (!m_busy && !m_done && keys_valid)});
    end

    // Raise in_valid and wait for the accepting edge; returns just after it.
    task automatic issue(input logic [31:0] p, input logic d, output int acc, output bit ok);
        @(posedge clk); #1;
        in_valid = 1'b1;
        pt       = p;
        decrypt  = d;
        ok       = 1'b0;
        for (int t = 0; t < 60; t++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        acc = 0;
        if (!ok) begin
            chk("accept_timeout", 32'd0, 32'd1);
            in_valid = 1'b0;
        end else begin
            @(posedge clk); #1;
            acc      = cyc;
            in_valid = 1'b0;
            pt       = ~p;      // later changes must not matter
            decrypt  = ~d;
        end
    endtask

    task automatic run_op(input logic [31:0] p, input logic d, input logic [31:0] exp, input int hold);
        int acc;
        bit ok;
        issue(p, d, acc, ok);
        if (ok) begin
            ok = 1'b0;
            for (int t = 0; t < 60; t++) begin
                @(negedge clk);
                if (out_valid) begin
                    ok = 1'b1;
                    break;
                end
            end
            chk("out_valid_seen", {31'd0, ok}, 32'd1);
            if (ok) begin
                chk("latency", 32'(cyc - acc), 32'(T));
                chk("ct_result", ct, exp);
                for (int h = 0; h < hold; h++) begin
                    @(posedge clk); #1;
                    in_valid = 1'b1;
                    pt       = 32'h0bad_f00d;
                end
                if (hold > 0) begin
                    @(negedge clk);
                    chk("ct_after_hold", ct, exp);
                    chk("ov_after_hold", {31'd0, out_valid}, 32'd1);
                end
                @(posedge clk); #1;
                in_valid  = 1'b0;
                out_ready = 1'b1;
                @(posedge clk); #1;
                out_ready = 1'b0;
            end
        end
    endtask

    logic [31:0] vec [4] = '{32'h6565_6877, 32'h0000_0000, 32'hffff_ffff, 32'h1234_5678};

    initial begin : main
        int  acc;
        bit  ok;
        int  nacc;
        int  accs [4];
        int  nres;
        int  seen;
        logic [15:0] tmp;
        logic        zb;

        // Key schedule for key words 1918 1110 0908 0100.
        rk[0] = 16'h0100;
        rk[1] = 16'h0908;
        rk[2] = 16'h1110;
        rk[3] = 16'h1918;
        for (int i = 4; i < T; i++) begin
            tmp   = rotr(rk[i-1], 3) ^ rk[i-3];
            tmp   = tmp ^ rotr(tmp, 1);
            zb    = z_seq[6'(61 - ((i - 4) % 62))];
            rk[i] = ~rk[i-4] ^ tmp ^ {15'd0, zb} ^ 16'd3;
        end
        for (int i = 0; i < T; i++) keys[i] = rk[i];

        // Pin the reference itself to the published vector.
        chk("model_enc", enc_ref(32'h6565_6877), 32'hc69b_e9bb);
        chk("model_dec", dec_ref(32'hc69b_e9bb), 32'h6565_6877);

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ct", ct, 32'd0);
        chk("rst_ov", {31'd0, out_valid}, 32'd0);
        @(posedge clk); #1;
        nReset     = 1'b1;
        keys_valid = 1'b1;
        @(negedge clk);
        chk("in_ready_after_rst", {31'd0, in_ready}, 32'd1);

        // Reference vectors and backpressure.
        run_op(32'h6565_6877, 1'b0, 32'hc69b_e9bb, 0);
        run_op(32'hc69b_e9bb, 1'b1, 32'h6565_6877, 0);
        run_op(32'h6565_6877, 1'b0, 32'hc69b_e9bb, 10);

        foreach (vec[i]) begin
            run_op(vec[i], 1'b0, enc_ref(vec[i]), 0);
            run_op(enc_ref(vec[i]), 1'b1, vec[i], 0);
        end

        // Abort: keys_valid drops after five rounds.
        issue(32'h6565_6877, 1'b0, acc, ok);
        repeat (5) @(posedge clk);
        #1 keys_valid = 1'b0;
        @(posedge clk); #1;
        keys_valid = 1'b1;
        @(negedge clk);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("abort_no_ov", 32'(seen), 32'd0);
        run_op(32'hc69b_e9bb, 1'b1, 32'h6565_6877, 0);

        // Reset at round 17.
        issue(32'h6565_6877, 1'b0, acc, ok);
        repeat (17) @(posedge clk);
        #1 nReset = 1'b0;
        @(negedge clk);
        chk("mid_rst_ct", ct, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_ov", {31'd0, out_valid}, 32'd0);
        @(posedge clk); #1;
        nReset = 1'b1;
        @(negedge clk);
        chk("rel_in_ready", {31'd0, in_ready}, 32'd1);
        run_op(32'h6565_6877, 1'b0, 32'hc69b_e9bb, 0);

        // Back-to-back with in_valid and out_ready held high.
        @(posedge clk); #1;
        in_valid  = 1'b1;
        pt        = 32'h6565_6877;
        decrypt   = 1'b0;
        out_ready = 1'b1;
        nacc = 0;
        nres = 0;
        for (int t = 0; t < 120; t++) begin
            @(negedge clk);
            if (in_valid && in_ready && nacc < 4) begin
                accs[nacc] = cyc;
                nacc++;
            end
            if (out_valid) begin
                nres++;
                chk("b2b_ct", ct, 32'hc69b_e9bb);
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (40) @(posedge clk);
        #1 out_ready = 1'b0;
        chk("b2b_accepts", {31'd0, (nacc >= 3)}, 32'd1);
        if (nacc >= 3) begin
            chk("b2b_space1", 32'(accs[1] - accs[0]), 32'(T + 2));
            chk("b2b_space2", 32'(accs[2] - accs[1]), 32'(T + 2));
        end
        chk("b2b_results", {31'd0, (nres >= 2)}, 32'd1);

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
